// File: rtl/sram_port_arbiter_if.sv
// One sram-like port: address-phase request fields plus the addr_ok/data_ok handshake.
// The master modport issues requests; the slave modport accepts and answers them.
interface sram_port_arbiter_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (output req, wr, size, addr, wstrb, wdata,
                   input  addr_ok, data_ok, rdata);
   modport slave  (input  req, wr, size, addr, wstrb, wdata,
                   output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one sram-like port between the fetch and MEM-stage masters with data-first priority.
// An in-order owner FIFO routes each downstream response back to the master that issued it.
module sram_port_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   sram_port_arbiter_if.slave       inst,
   sram_port_arbiter_if.slave       data,
   sram_port_arbiter_if.master      mem,
   output logic [$clog2(DEPTH):0]   outstanding,
   output logic                     proto_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DEPTH-1:0] owner;
   logic [AW-1:0]    head;
   logic [AW-1:0]    tail;
   logic             full;
   logic             empty;
   logic             grant_d;
   logic             grant_i;
   logic             push;
   logic             pop;
   logic             head_id;

   assign full    = (outstanding == CW'(DEPTH));
   assign empty   = (outstanding == '0);
   assign grant_d = data.req && !full;
   assign grant_i = inst.req && !data.req && !full;
   assign push    = mem.req && mem.addr_ok;
   assign pop     = mem.data_ok && !empty;
   assign head_id = owner[head];

   always_comb begin
      mem.req   = grant_d | grant_i;
      mem.wr    = 1'b0;
      mem.size  = '0;
      mem.addr  = '0;
      mem.wstrb = '0;
      mem.wdata = '0;
      if (grant_d) begin
         mem.wr    = data.wr;
         mem.size  = data.size;
         mem.addr  = data.addr;
         mem.wstrb = data.wstrb;
         mem.wdata = data.wdata;
      end else if (grant_i) begin
         mem.wr    = inst.wr;
         mem.size  = inst.size;
         mem.addr  = inst.addr;
         mem.wstrb = inst.wstrb;
         mem.wdata = inst.wdata;
      end
   end

   assign data.addr_ok = grant_d & mem.addr_ok;
   assign inst.addr_ok = grant_i & mem.addr_ok;
   // A response with nothing tracked is dropped rather than routed to a stale owner.
   assign data.data_ok = pop & head_id;
   assign inst.data_ok = pop & ~head_id;
   assign data.rdata   = mem.rdata;
   assign inst.rdata   = mem.rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner       <= '0;
         head        <= '0;
         tail        <= '0;
         outstanding <= '0;
         proto_err   <= 1'b0;
      end else begin
         if (push) begin
            owner[tail] <= grant_d;
            tail        <= tail + AW'(1);
         end
         if (pop) begin
            head <= head + AW'(1);
         end
         if (push && !pop) begin
            outstanding <= outstanding + CW'(1);
         end else if (pop && !push) begin
            outstanding <= outstanding - CW'(1);
         end
         if (mem.data_ok && empty) begin
            proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random traffic, all checked
// against a queue-of-owners reference model of the arbiter and response routing.
module tb_sram_port_arbiter;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] outstanding;
   logic       proto_err;

   int total = 0;
   int bad   = 0;

   bit exp_q[$];
   bit exp_err = 1'b0;

   sram_port_arbiter_if inst_bus ();
   sram_port_arbiter_if data_bus ();
   sram_port_arbiter_if mem_bus ();

   sram_port_arbiter #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .inst        (inst_bus),
      .data        (data_bus),
      .mem         (mem_bus),
      .outstanding (outstanding),
      .proto_err   (proto_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 0; inst_bus.addr = 0;
      inst_bus.wstrb = 0; inst_bus.wdata = 0;
      data_bus.req = 0; data_bus.wr = 0; data_bus.size = 0; data_bus.addr = 0;
      data_bus.wstrb = 0; data_bus.wdata = 0;
      mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = 0;
   endtask

   // Called at posedge+1 with inputs already driven; checks mid-cycle, then applies the edge to the model.
   task automatic step();
      bit          full, gd, gi, aok, dok, hid;
      logic [31:0] e_addr, e_wdata;
      logic [6:0]  e_ctl;
      #3;
      full = (exp_q.size() == DEPTH);
      gd   = data_bus.req && !full;
      gi   = inst_bus.req && !data_bus.req && !full;
      aok  = mem_bus.addr_ok;
      dok  = mem_bus.data_ok;
      e_addr = 0; e_wdata = 0; e_ctl = 0;
      if (gd) begin
         e_addr = data_bus.addr; e_wdata = data_bus.wdata;
         e_ctl  = {data_bus.wr, data_bus.size, data_bus.wstrb};
      end else if (gi) begin
         e_addr = inst_bus.addr; e_wdata = inst_bus.wdata;
         e_ctl  = {inst_bus.wr, inst_bus.size, inst_bus.wstrb};
      end
      check_val("outstanding", outstanding, exp_q.size());
      check_val("proto_err", proto_err, exp_err);
      check_val("mem_req", mem_bus.req, gd | gi);
      check_val("mem_addr", mem_bus.addr, e_addr);
      check_val("mem_wdata", mem_bus.wdata, e_wdata);
      check_val("mem_wr_size_wstrb", {mem_bus.wr, mem_bus.size, mem_bus.wstrb}, e_ctl);
      check_val("addr_ok_i_d", {inst_bus.addr_ok, data_bus.addr_ok}, {gi & aok, gd & aok});
      hid = (exp_q.size() > 0) ? exp_q[0] : 1'b0;
      if (dok && exp_q.size() > 0)
         check_val("data_ok_i_d", {inst_bus.data_ok, data_bus.data_ok}, {!hid, hid});
      else
         check_val("data_ok_i_d", {inst_bus.data_ok, data_bus.data_ok}, 2'b00);
      if (dok) begin
         check_val("inst_rdata", inst_bus.rdata, mem_bus.rdata);
         check_val("data_rdata", data_bus.rdata, mem_bus.rdata);
      end
      @(posedge clk);
      if (dok) begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         else exp_err = 1'b1;
      end
      if ((gd | gi) && aok) exp_q.push_back(gd);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH && exp_q.size() > 0; i++) begin
         idle();
         mem_bus.data_ok = 1; mem_bus.rdata = $urandom;
         step();
      end
      idle();
   endtask

   initial begin
      idle();
      #2;
      check_val("rst_outstanding", outstanding, 0);
      check_val("rst_proto_err", proto_err, 0);
      check_val("rst_data_ok", {inst_bus.data_ok, data_bus.data_ok}, 2'b00);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // single fetch
      inst_bus.req = 1; inst_bus.addr = 32'h1C00_0000; inst_bus.wstrb = 0; mem_bus.addr_ok = 1;
      step();
      idle(); step();
      mem_bus.data_ok = 1; mem_bus.rdata = 32'h0280_0C0C;
      #3;
      check_val("fetch_inst_rdata", inst_bus.rdata, 32'h0280_0C0C);
      check_val("fetch_inst_data_ok", inst_bus.data_ok, 1);
      #(-0); step();
      idle(); step();

      // contention: data store wins, fetch granted once data drops req
      inst_bus.req = 1; inst_bus.addr = 32'h1C00_0004;
      data_bus.req = 1; data_bus.wr = 1; data_bus.size = 2; data_bus.addr = 32'h1C00_1000;
      data_bus.wstrb = 4'hF; data_bus.wdata = 32'hDEAD_BEEF; mem_bus.addr_ok = 1;
      step();
      data_bus.req = 0;
      step();
      drain();

      // order routing: data, inst, data
      data_bus.req = 1; data_bus.addr = 32'h100; mem_bus.addr_ok = 1; step();
      data_bus.req = 0; inst_bus.req = 1; inst_bus.addr = 32'h200; step();
      inst_bus.req = 0; data_bus.req = 1; data_bus.addr = 32'h300; step();
      idle(); mem_bus.data_ok = 1; mem_bus.rdata = 32'h11; step();
      mem_bus.rdata = 32'h22; step();
      mem_bus.rdata = 32'h33; step();
      idle(); step();

      // full: four fetches, fifth stalls until a pop frees a slot
      inst_bus.req = 1; mem_bus.addr_ok = 1;
      for (int i = 0; i < DEPTH; i++) begin inst_bus.addr = 32'h1C00_0000 + 4 * i; step(); end
      inst_bus.addr = 32'h1C00_0040;
      step();
      check_val("full_outstanding", outstanding, DEPTH);
      mem_bus.data_ok = 1; mem_bus.rdata = 32'hAAAA_0001; step();
      mem_bus.data_ok = 0; step();
      check_val("refill_outstanding", outstanding, DEPTH);
      drain();

      // simultaneous push+pop at two outstanding
      data_bus.req = 1; mem_bus.addr_ok = 1; step();
      data_bus.req = 0; inst_bus.req = 1; step();
      inst_bus.req = 0; data_bus.req = 1; mem_bus.data_ok = 1; mem_bus.rdata = 32'h55; step();
      check_val("pushpop_outstanding", outstanding, 2);
      drain();

      // spurious response with nothing tracked
      idle(); mem_bus.data_ok = 1; step();
      idle(); step();
      check_val("spurious_proto_err", proto_err, 1);

      // asynchronous reset with three outstanding
      inst_bus.req = 1; mem_bus.addr_ok = 1;
      for (int i = 0; i < 3; i++) step();
      idle();
      #2; rst_n = 1'b0; #1;
      check_val("async_rst_outstanding", outstanding, 0);
      check_val("async_rst_proto_err", proto_err, 0);
      exp_q.delete(); exp_err = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         inst_bus.req   = ($urandom_range(0, 3) != 0);
         inst_bus.wr    = $urandom_range(0, 1);
         inst_bus.size  = $urandom_range(0, 3);
         inst_bus.addr  = $urandom;
         inst_bus.wstrb = $urandom_range(0, 15);
         inst_bus.wdata = $urandom;
         data_bus.req   = ($urandom_range(0, 2) == 0);
         data_bus.wr    = $urandom_range(0, 1);
         data_bus.size  = $urandom_range(0, 3);
         data_bus.addr  = $urandom;
         data_bus.wstrb = $urandom_range(0, 15);
         data_bus.wdata = $urandom;
         mem_bus.addr_ok = ($urandom_range(0, 9) < 7);
         mem_bus.data_ok = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
         mem_bus.rdata   = $urandom;
         step();
      end
      drain();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one sram-like memory port between the instruction-fetch master and the MEM-stage data master of the CPU pipeline. Address-phase requests are arbitrated with data-first priority and forwarded combinationally. Each accepted request's owner is recorded in an in-order tracking FIFO so that each downstream `data_ok`/`rdata` is routed back to the master that issued it. Sits between the pipeline's two sram-like masters and the sram-like-to-bus bridge.

## Interface
- `DEPTH`, 4: maximum outstanding (accepted, not yet answered) transactions; power of two, 2..16.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `inst_req`, `inst_wr`  in  1  fetch master request / write flag.
- `inst_size`  in  2  transfer size.
- `inst_addr`  in  32  address.
- `inst_wstrb`  in  4  byte strobes.
- `inst_wdata`  in  32  write data.
- `inst_addr_ok`  out  1  fetch request accepted this cycle.
- `inst_data_ok`  out  1  fetch response valid this cycle.
- `inst_rdata`  out  32  fetch read data.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wstrb`, `data_wdata`, `data_addr_ok`, `data_data_ok`, `data_rdata`: same widths and meanings as the `inst_*` ports, for the MEM-stage master.
- `mem_req`, `mem_wr`  out  1  downstream request / write flag.
- `mem_size`  out  2, `mem_addr`  out  32, `mem_wstrb`  out  4, `mem_wdata`  out  32: forwarded fields of the granted master.
- `mem_addr_ok`  in  1  downstream accepted request.
- `mem_data_ok`  in  1  downstream response valid.
- `mem_rdata`  in  32  downstream read data.
- `outstanding`  out  $clog2(DEPTH)+1  current tracked transaction count.
- `proto_err`  out  1  sticky: `mem_data_ok` arrived with the tracking FIFO empty.

## Operation
- Grant is combinational and recomputed every cycle:
  - `grant_d = data_req && !full`
  - `grant_i = inst_req && !data_req && !full`
  - `full = (outstanding == DEPTH)`.
- `mem_req = grant_d | grant_i`. `mem_wr`, `mem_size`, `mem_addr`, `mem_wstrb`, `mem_wdata` are muxed from the granted master. When neither master is granted, these fields are all zero.
- `data_addr_ok = grant_d & mem_addr_ok`; `inst_addr_ok = grant_i & mem_addr_ok`. Never both high in the same cycle.
- Push condition: `mem_req && mem_addr_ok`. On push, the owner ID (1 = data, 0 = inst) is written at the FIFO tail and the tail advances modulo DEPTH.
- `head_id` = ID at the FIFO head.
- Response routing, when `mem_data_ok` is high and the FIFO is non-empty:
  - `data_data_ok = mem_data_ok & head_id`
  - `inst_data_ok = mem_data_ok & !head_id`
  - Head advances (pop).
- `inst_rdata` and `data_rdata` both equal `mem_rdata` unconditionally; the masters qualify with their own `data_ok`.
- `outstanding` changes by +1 on push-only, −1 on pop-only, and is unchanged on simultaneous push+pop.
- The downstream slave returns responses strictly in acceptance order. It never asserts `data_ok` for a request in the same cycle as that request's `addr_ok`.
- `mem_data_ok` with the FIFO empty:
  - No pop occurs and both `*_data_ok` stay 0.
  - `proto_err` is set to 1 and holds until reset.
- Full: `mem_req = 0`, both `addr_ok` = 0. Masters hold `req` stable; the stall ends the cycle after a pop.
- Masters may hold `req` across cycles. A pending `inst_req` loses the grant to `data_req` whenever both are present.
- Reset (`rst_n` low, any time, including mid-transaction):
  - Head, tail and `outstanding` cleared to 0; `proto_err` cleared to 0.
  - In-flight transactions are discarded. The downstream slave and both masters are reset together with the block.

## Timing
- Address phase: zero-cycle combinational path from `*_req`/fields to `mem_*`, and from `mem_addr_ok` to `*_addr_ok`.
- Response phase: zero-cycle combinational path from `mem_data_ok` to `*_data_ok`. No added latency.
- FIFO pointers, `outstanding` and `proto_err` update on the `clk` rising edge after the event.
- A request accepted in cycle N can be answered no earlier than cycle N+1. A slot freed by a pop in cycle N is usable in cycle N+1.
- Values while `rst_n` is low / immediately after release:
  - `outstanding = 0`, `proto_err = 0`.
  - `inst_data_ok = data_data_ok = 0`.
  - `mem_req` follows the inputs, since the FIFO is not full.

## Test plan
- Single fetch: `inst_req=1`, `inst_addr=0x1C000000`, slave `addr_ok` in cycle 0 and `data_ok` with `rdata=0x02800C0C` in cycle 2.
  - Expect `inst_addr_ok` in cycle 0, `outstanding=1` in cycles 1–2, and `inst_data_ok=1` with `inst_rdata=0x02800C0C` in cycle 2.
  - Expect `data_data_ok=0` throughout and `outstanding=0` in cycle 3.
- Contention: `inst_req` and `data_req` (SW, `addr=0x1C001000`, `wstrb=4'hF`, `wdata=0xDEADBEEF`) both high, with `addr_ok` always 1.
  - Cycle 0: `mem_addr=0x1C001000`, `mem_wr=1`, `data_addr_ok=1`, `inst_addr_ok=0`.
  - Cycle 1 (data master drops `req`): fetch granted.
- Order routing: accept data, then inst, then data; the slave returns 3 `data_ok` pulses with `rdata` 0x11, 0x22, 0x33.
  - Expect `data_data_ok` (0x11), then `inst_data_ok` (0x22), then `data_data_ok` (0x33).
- Full: DEPTH=4, 4 fetches accepted with no responses. A 5th fetch sees `mem_req=0`, `inst_addr_ok=0` and `outstanding=4`.
  - One `data_ok` pops an entry; the next cycle the 5th fetch is accepted and `outstanding` returns to 4.
- Simultaneous push+pop at `outstanding=2` → `outstanding` stays 2 and the correct head owner gets `data_ok`.
  - Spurious `mem_data_ok` at `outstanding=0` → no `*_data_ok`, `proto_err=1` from the next cycle.
- Asynchronous reset: assert `rst_n=0` mid-cycle with 3 outstanding → `outstanding` and `proto_err` read 0 immediately, without waiting for a clock edge.
